cpu_controller: RTL
===================

# cpu_controller

Control unit for the 16-bit TCES330 processor: fetches instructions from a synchronous instruction ROM, decodes them, and sequences the `DataPath` control inputs (`D_Addr`, `D_wr`, `RF_s`, `RF_W_*`, `RF_R*_addr`, `Alu_s0`). The block is the initiator driving the datapath's control interface, one instruction at a time. It holds the program counter (PC), the instruction register (IR) and the sequencing FSM.

## Interface
Parameters:
- PC_W, 7: PC / instruction-ROM address width (128 words).

Ports:
- Clk  in  1  clock; all state updates on posedge.
- Reset_n  in  1  synchronous, active-low reset.
- IM_Data  in  16  instruction word from ROM, valid one cycle after `IM_Addr` is stable.
- IM_Addr  out  PC_W  ROM address; always equals PC.
- D_Addr  out  8  data-memory address.
- D_wr  out  1  data-memory write enable.
- RF_s  out  1  register-file write mux select: 1 = RAM, 0 = ALU.
- RF_W_en  out  1  register-file write enable.
- RF_W_addr, RF_Ra_addr, RF_Rb_addr  out  4 each  register addresses.
- Alu_s0  out  3  ALU function select.
- IR  out  16  instruction register (debug).
- State  out  4  current FSM state encoding (debug).

## Operation
- Instruction format: opcode IR[15:12].
  - NOOP 0000.
  - STORE 0001: Ra = IR[11:8], D_Addr = IR[7:0].
  - LOAD 0010: D_Addr = IR[11:4], Rd = IR[3:0].
  - ADD 0011 / SUB 0100: Ra = IR[11:8], Rb = IR[7:4], Rd = IR[3:0].
  - HALT 0101.
- ALU codes: PASS 3'd0, ADD 3'd1, SUB 3'd2.
- Defaults in every state unless listed: `D_wr`, `RF_W_en`, `RF_s` = 0; `Alu_s0` = PASS; address outputs decoded combinationally from IR fields per opcode, 0 for unused fields.
- States and transitions:
  - INIT → FETCH.
  - FETCH: IR ← IM_Data, PC ← PC+1 at the closing edge; → DECODE.
  - DECODE: branch on IR opcode to NOOP, STORE, LOAD_A, ADD, SUB or HALT.
  - NOOP → FETCH.
  - LOAD_A: `D_Addr` driven, `RF_s`=1, `RF_W_en`=0; → LOAD_B.
  - LOAD_B: `D_Addr` held, `RF_s`=1, `RF_W_en`=1, `RF_W_addr`=Rd; → FETCH.
  - STORE: `D_wr`=1, `RF_Ra_addr`=Ra, `D_Addr` driven; → FETCH.
  - ADD / SUB: `RF_Ra_addr`, `RF_Rb_addr`, `RF_W_addr` driven, `RF_s`=0, `RF_W_en`=1, `Alu_s0`=ADD/SUB; → FETCH.
  - HALT: all enables 0, PC and IR frozen; stays until reset.
- Undefined opcodes (0110–1111) execute as NOOP.
- PC wrap: 2^PC_W−1 + 1 → 0, silently.

## Timing
- Reset (Reset_n low at a posedge): State = INIT, PC = 0, IR = 0, all control outputs 0. Reset overrides any state, including mid-LOAD. A LOAD_A or LOAD_B aborted by reset performs no register write after reset.
- Per-instruction cycles counted from FETCH entry:
  - NOOP, STORE, ADD, SUB: 3 cycles.
  - LOAD: 4 cycles, covering the 1-cycle RAM read latency.
- The first FETCH occurs one cycle after reset deasserts: INIT lasts one cycle, which also covers ROM latency for PC=0.
- PC is stable for at least one full cycle before every FETCH, so the synchronous ROM data is valid.
- Control outputs are Moore, derived from State and IR only. There is no combinational path from IM_Data to any output other than the IR register.

## Configuration
- `CPU_ILLEGAL_OP_HALT_EN` defined: undefined opcodes transition DECODE → HALT.
- Not defined: undefined opcodes execute as NOOP (default).
- Nothing else changes.

## Structure
- Shared package `cpu_pkg`:
  - state enum (INIT, FETCH, DECODE, NOOP, LOAD_A, LOAD_B, STORE, ADD, SUB, HALT, 4-bit encoding);
  - opcode constants;
  - ALU select constants (reused by ALU and DataPath);
  - IR field bit positions.
- One sub-module, `program_counter`: PC_W-bit register with synchronous active-low clear and increment enable from FETCH.

## Test plan
- Reset mid-run: assert Reset_n=0 during LOAD_B → next cycle State=INIT, PC=0, RF_W_en=0, D_wr=0.
- LOAD: ROM[0]=16'h2005 (D_Addr 0x00, Rd 5).
  - LOAD_A: D_Addr=0x00, RF_s=1, RF_W_en=0.
  - LOAD_B: RF_W_en=1, RF_W_addr=5.
  - PC=1; 4 cycles from FETCH.
- STORE: ROM word 16'h1209 → single cycle with D_wr=1, RF_Ra_addr=2, D_Addr=0x09, RF_W_en=0.
- ADD then SUB: 16'h3123, 16'h4124.
  - ADD: Alu_s0=1, Ra=1, Rb=2, RF_W_addr=3, RF_s=0, RF_W_en=1.
  - SUB: same with Alu_s0=2, RF_W_addr=4.
  - 3 cycles each.
- HALT: 16'h5000 → State=HALT, PC frozen, all enables 0 for 20 cycles; reset returns to INIT.
- Undefined opcode 16'hF000:
  - Without the macro: behaves as NOOP, PC advances.
  - With `CPU_ILLEGAL_OP_HALT_EN`: enters HALT.
- PC wrap: after fetching address 127, PC=0.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Brief    : Shared types and constants for the TCES330 control unit.
// Revision : 1.0
// ============================================================================
package cpu_pkg;

    typedef enum logic [3:0] {
        INIT   = 4'd0,
        FETCH  = 4'd1,
        DECODE = 4'd2,
        NOOP   = 4'd3,
        LOAD_A = 4'd4,
        LOAD_B = 4'd5,
        STORE  = 4'd6,
        ADD    = 4'd7,
        SUB    = 4'd8,
        HALT   = 4'd9
    } state_t;

    localparam logic [3:0] c_OP_NOOP  = 4'h0;
    localparam logic [3:0] c_OP_STORE = 4'h1;
    localparam logic [3:0] c_OP_LOAD  = 4'h2;
    localparam logic [3:0] c_OP_ADD   = 4'h3;
    localparam logic [3:0] c_OP_SUB   = 4'h4;
    localparam logic [3:0] c_OP_HALT  = 4'h5;

    localparam logic [2:0] c_ALU_PASS = 3'd0;
    localparam logic [2:0] c_ALU_ADD  = 3'd1;
    localparam logic [2:0] c_ALU_SUB  = 3'd2;

    localparam int c_OP_HI      = 15;
    localparam int c_OP_LO      = 12;
    localparam int c_RA_HI      = 11;
    localparam int c_RA_LO      = 8;
    localparam int c_RB_HI      = 7;
    localparam int c_RB_LO      = 4;
    localparam int c_RD_HI      = 3;
    localparam int c_RD_LO      = 0;
    localparam int c_ST_ADDR_HI = 7;
    localparam int c_ST_ADDR_LO = 0;
    localparam int c_LD_ADDR_HI = 11;
    localparam int c_LD_ADDR_LO = 4;

endpackage
`default_nettype wire

// File: rtl/program_counter.sv
`default_nettype none
// ============================================================================
// Module   : program_counter
// Brief    : PC register, synchronous active-low clear, increment on FETCH.
// Revision : 1.0
// ============================================================================
module program_counter #(
    parameter int PC_W = 7
) (
    input  logic            Clk,
    input  logic            Reset_n,
    input  logic            inc_en,
    output logic [PC_W-1:0] pc
);

    logic [PC_W-1:0] r_pc;

    // Wraps silently from all-ones to zero.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_pc <= '0;
        end else if (inc_en) begin
            r_pc <= r_pc + {{(PC_W-1){1'b0}}, 1'b1};
        end
    end

    assign pc = r_pc;

endmodule
`default_nettype wire

// File: rtl/cpu_controller.sv
`default_nettype none
// ============================================================================
// Module   : cpu_controller
// Brief    : Fetch/decode/sequence control unit for the TCES330 datapath.
//            Define CPU_ILLEGAL_OP_HALT_EN to halt on undefined opcodes.
// Revision : 1.0
// ============================================================================
module cpu_controller
    import cpu_pkg::*;
#(
    parameter int PC_W = 7
) (
    input  logic            Clk,
    input  logic            Reset_n,
    input  logic [15:0]     IM_Data,
    output logic [PC_W-1:0] IM_Addr,
    output logic [7:0]      D_Addr,
    output logic            D_wr,
    output logic            RF_s,
    output logic            RF_W_en,
    output logic [3:0]      RF_W_addr,
    output logic [3:0]      RF_Ra_addr,
    output logic [3:0]      RF_Rb_addr,
    output logic [2:0]      Alu_s0,
    output logic [15:0]     IR,
    output logic [3:0]      State
);

    state_t          r_state;
    state_t          w_next;
    logic [15:0]     r_ir;
    logic [3:0]      w_op;
    logic            w_fetch;
    logic [PC_W-1:0] w_pc;

    assign w_op    = r_ir[c_OP_HI:c_OP_LO];
    assign w_fetch = (r_state == FETCH);

    program_counter #(.PC_W(PC_W)) u_pc (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .inc_en  (w_fetch),
        .pc      (w_pc)
    );

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_state <= INIT;
            r_ir    <= '0;
        end else begin
            r_state <= w_next;
            if (w_fetch) begin
                r_ir <= IM_Data;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            INIT:   w_next = FETCH;
            FETCH:  w_next = DECODE;
            DECODE: begin
                case (w_op)
                    c_OP_NOOP:  w_next = NOOP;
                    c_OP_STORE: w_next = STORE;
                    c_OP_LOAD:  w_next = LOAD_A;
                    c_OP_ADD:   w_next = ADD;
                    c_OP_SUB:   w_next = SUB;
                    c_OP_HALT:  w_next = HALT;
`ifdef CPU_ILLEGAL_OP_HALT_EN
                    default:    w_next = HALT;
`else
                    default:    w_next = NOOP;
`endif
                endcase
            end
            LOAD_A: w_next = LOAD_B;
            NOOP, STORE, LOAD_B, ADD, SUB: w_next = FETCH;
            HALT:   w_next = HALT;
            default: w_next = INIT;
        endcase
    end

    // Addresses follow the IR fields in every state; enables follow the state.
    always_comb begin
        D_Addr     = '0;
        D_wr       = 1'b0;
        RF_s       = 1'b0;
        RF_W_en    = 1'b0;
        RF_W_addr  = '0;
        RF_Ra_addr = '0;
        RF_Rb_addr = '0;
        Alu_s0     = c_ALU_PASS;
        case (w_op)
            c_OP_STORE: begin
                RF_Ra_addr = r_ir[c_RA_HI:c_RA_LO];
                D_Addr     = r_ir[c_ST_ADDR_HI:c_ST_ADDR_LO];
            end
            c_OP_LOAD: begin
                D_Addr    = r_ir[c_LD_ADDR_HI:c_LD_ADDR_LO];
                RF_W_addr = r_ir[c_RD_HI:c_RD_LO];
            end
            c_OP_ADD, c_OP_SUB: begin
                RF_Ra_addr = r_ir[c_RA_HI:c_RA_LO];
                RF_Rb_addr = r_ir[c_RB_HI:c_RB_LO];
                RF_W_addr  = r_ir[c_RD_HI:c_RD_LO];
            end
            default: ;
        endcase
        case (r_state)
            LOAD_A: RF_s = 1'b1;
            LOAD_B: begin
                RF_s    = 1'b1;
                RF_W_en = 1'b1;
            end
            STORE:  D_wr = 1'b1;
            ADD: begin
                RF_W_en = 1'b1;
                Alu_s0  = c_ALU_ADD;
            end
            SUB: begin
                RF_W_en = 1'b1;
                Alu_s0  = c_ALU_SUB;
            end
            default: ;
        endcase
    end

    assign IM_Addr = w_pc;
    assign IR      = r_ir;
    assign State   = r_state;

endmodule
`default_nettype wire
